scr1_tcm_dmem_ctrl: RTL

- Data-side initiator for the TCM dual-port memory.
- Accepts core data-memory requests on the req/ack/resp handshake and converts them into port-B memory accesses: read enable, write enable, byte write mask, word address and lane-shifted write data.
- Returns lane-aligned read data and an OKAY/ER response.
- Sits between the core LSU interconnect and port B of the TCM memory. Port A, the fetch side, is not touched.

---
 rtl/scr1_tcm_pkg.sv | 24 ++
 rtl/scr1_tcm_lane_align.sv | 50 +++++
 rtl/scr1_tcm_dmem_ctrl.sv | 102 ++++++++++
 3 files changed

// File: rtl/scr1_tcm_pkg.sv
// Shared TCM types: memory command, access width and response codes.
package scr1_tcm_pkg;

  localparam int unsigned SCR1_TCM_LANES = 4;

  typedef enum logic {
    RD = 1'b0,
    WR = 1'b1
  } type_scr1_mem_cmd_e;

  typedef enum logic [1:0] {
    BYTE  = 2'b00,
    HWORD = 2'b01,
    WORD  = 2'b10,
    ERR   = 2'b11
  } type_scr1_mem_width_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    OKAY = 2'b01,
    ER   = 2'b10
  } type_scr1_mem_resp_e;

endpackage

// File: rtl/scr1_tcm_lane_align.sv
// Byte-lane steering between LSB-aligned core data and the 32-bit TCM word:
// write replication plus byte mask, and read extraction with zero extension.
module scr1_tcm_lane_align
  import scr1_tcm_pkg::*;
(
  input  type_scr1_mem_width_e             wr_width,
  input  logic [1:0]                       wr_offset,
  input  logic [31:0]                      wr_data,
  output logic [31:0]                      wr_lanes,
  output logic [SCR1_TCM_LANES-1:0]        wr_mask,
  input  type_scr1_mem_width_e             rd_width,
  input  logic [1:0]                       rd_offset,
  input  logic [31:0]                      rd_lanes,
  output logic [31:0]                      rd_data
);

  logic [31:0] rd_shifted;

  always_comb begin
    wr_lanes = '0;
    wr_mask  = '0;
    case (wr_width)
      BYTE: begin
        wr_lanes = {4{wr_data[7:0]}};
        wr_mask  = 4'b0001 << wr_offset;
      end
      HWORD: begin
        wr_lanes = {2{wr_data[15:0]}};
        wr_mask  = 4'b0011 << wr_offset;
      end
      WORD: begin
        wr_lanes = wr_data;
        wr_mask  = '1;
      end
      default: ;
    endcase
  end

  always_comb begin
    rd_shifted = rd_lanes >> {rd_offset, 3'b000};
    rd_data    = '0;
    case (rd_width)
      BYTE:    rd_data = {24'h0, rd_shifted[7:0]};
      HWORD:   rd_data = {16'h0, rd_shifted[15:0]};
      WORD:    rd_data = rd_shifted;
      default: ;
    endcase
  end

endmodule

// File: rtl/scr1_tcm_dmem_ctrl.sv
// Data-side TCM initiator: core req/ack/resp handshake to memory port B,
// with a single response register giving one-cycle response latency.
module scr1_tcm_dmem_ctrl
  import scr1_tcm_pkg::*;
#(
  parameter int unsigned SCR1_SIZE   = 32'h00010000,
  parameter int unsigned SCR1_AWIDTH = 32
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           dmem_req,
  input  logic                           dmem_cmd,
  input  logic [1:0]                     dmem_width,
  input  logic [SCR1_AWIDTH-1:0]         dmem_addr,
  input  logic [31:0]                    dmem_wdata,
  output logic                           dmem_req_ack,
  output logic [31:0]                    dmem_rdata,
  output logic [1:0]                     dmem_resp,
  output logic                           mem_renb,
  output logic                           mem_wenb,
  output logic [3:0]                     mem_webb,
  output logic [$clog2(SCR1_SIZE)-3:0]   mem_addrb,
  output logic [31:0]                    mem_datab,
  input  logic [31:0]                    mem_qb
);

  localparam int unsigned SIZE_W = $clog2(SCR1_SIZE);
  localparam logic [SCR1_AWIDTH:0] SIZE_LIM = (SCR1_AWIDTH+1)'(SCR1_SIZE);

  type_scr1_mem_width_e req_width;
  type_scr1_mem_cmd_e   req_cmd;
  logic                 req_err;
  logic [31:0]          wr_lanes;
  logic [3:0]           wr_mask;
  logic [31:0]          rd_data;

  logic                 resp_pending;
  logic                 resp_err;
  type_scr1_mem_cmd_e   resp_cmd;
  type_scr1_mem_width_e resp_width;
  logic [1:0]           resp_offset;

  assign req_width    = type_scr1_mem_width_e'(dmem_width);
  assign req_cmd      = type_scr1_mem_cmd_e'(dmem_cmd);
  assign dmem_req_ack = dmem_req & rst_n;

  always_comb begin
    req_err = ({1'b0, dmem_addr} >= SIZE_LIM);
    case (req_width)
      HWORD:   if (dmem_addr[0]) req_err = 1'b1;
      WORD:    if (|dmem_addr[1:0]) req_err = 1'b1;
      ERR:     req_err = 1'b1;
      default: ;
    endcase
  end

  scr1_tcm_lane_align i_lane_align (
    .wr_width  (req_width),
    .wr_offset (dmem_addr[1:0]),
    .wr_data   (dmem_wdata),
    .wr_lanes  (wr_lanes),
    .wr_mask   (wr_mask),
    .rd_width  (resp_width),
    .rd_offset (resp_offset),
    .rd_lanes  (mem_qb),
    .rd_data   (rd_data)
  );

  // Port-B signals are forced to zero outside good accesses so the memory
  // never sees a stray address or mask.
  assign mem_renb  = dmem_req_ack & ~req_err & (req_cmd == RD);
  assign mem_wenb  = dmem_req_ack & ~req_err & (req_cmd == WR);
  assign mem_addrb = (mem_renb | mem_wenb) ? dmem_addr[SIZE_W-1:2] : '0;
  assign mem_webb  = mem_wenb ? wr_mask : '0;
  assign mem_datab = mem_wenb ? wr_lanes : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_pending <= 1'b0;
      resp_err     <= 1'b0;
      resp_cmd     <= RD;
      resp_width   <= BYTE;
      resp_offset  <= '0;
    end else if (dmem_req_ack) begin
      resp_pending <= 1'b1;
      resp_err     <= req_err;
      resp_cmd     <= req_cmd;
      resp_width   <= req_width;
      resp_offset  <= dmem_addr[1:0];
    end else begin
      resp_pending <= 1'b0;
      resp_err     <= 1'b0;
      resp_cmd     <= RD;
      resp_width   <= BYTE;
      resp_offset  <= '0;
    end
  end

  assign dmem_resp  = resp_pending ? (resp_err ? ER : OKAY) : IDLE;
  assign dmem_rdata = (resp_pending & ~resp_err & (resp_cmd == RD)) ? rd_data : '0;

endmodule
